// File: rtl/data_bus_ctrl_if.sv
// Handshaked data bus between the MEM-stage sequencer (master) and the
// memory/bus fabric (slave). Request fields are held by the master for the
// whole address phase; addr_ok/data_ok/rdata come back from the slave.
interface data_bus_ctrl_if;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_wr,
        output bus_size,
        output bus_addr,
        output bus_wdata,
        output bus_wstrb,
        input  bus_addr_ok,
        input  bus_data_ok,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_wr,
        input  bus_size,
        input  bus_addr,
        input  bus_wdata,
        input  bus_wstrb,
        output bus_addr_ok,
        output bus_data_ok,
        output bus_rdata
    );
endinterface

// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: sequences one MEM-stage load/store onto the handshaked data
// bus (address phase, then data phase), stalls the pipeline while the access
// is outstanding, and holds the returned read data until the pipeline takes it.
//
// Optional feature: define DATA_BUS_ALIGN_CHECK_EN to reject misaligned
// half/word accesses in IDLE without touching the bus (error reported in DONE).
module data_bus_ctrl #(
    parameter int unsigned WAIT_MAX = 255   // WAIT cycles before timeout, 1..255
) (
    input  logic                   clk,
    input  logic                   rst,          // asynchronous, active-low
    input  logic                   mem_req_en,
    input  logic [3:0]             mem_wen,
    input  logic [1:0]             mem_size,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_wdata,
    input  logic                   pipe_hold,
    data_bus_ctrl_if.master        bus,
    output logic                   stallreq_mem,
    output logic [31:0]            rdata_out,
    output logic                   rdata_valid,
    output logic                   bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  size_q;
    logic        wr_q;
    logic        req_q;
    logic [31:0] rdata_q;
    logic        valid_q;
    logic        err_q;
    logic [7:0]  wait_cnt;

`ifdef DATA_BUS_ALIGN_CHECK_EN
    // Half needs addr[0]=0; word (and reserved size, treated as word) needs addr[1:0]=0.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = lsb[0];
            default: bad = (lsb != 2'b00);
        endcase
        return bad;
    endfunction
`endif

    // Access sequencer: captures the request, runs the bus phases, and holds the result.
    // NOTE: every register here uses non-blocking assignment so all state updates
    // see the pre-edge values; blocking would make the result order-dependent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            size_q   <= '0;
            wr_q     <= 1'b0;
            req_q    <= 1'b0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req_en) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wen;
                        size_q  <= mem_size;
                        wr_q    <= (mem_wen != 4'b0000);
`ifdef DATA_BUS_ALIGN_CHECK_EN
                        if (misaligned(mem_size, mem_addr[1:0])) begin
                            // Never reaches the bus; report straight from DONE.
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            valid_q <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            req_q <= 1'b1;
                            state <= S_REQ;
                        end
`else
                        req_q <= 1'b1;
                        state <= S_REQ;
`endif
                    end
                end

                S_REQ: begin
                    // data_ok is only meaningful together with or after addr_ok.
                    if (bus.bus_addr_ok) begin
                        req_q <= 1'b0;
                        if (bus.bus_data_ok) begin
                            rdata_q <= bus.bus_rdata;
                            valid_q <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            wait_cnt <= '0;
                            state    <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (bus.bus_data_ok) begin
                        // Stores latch the bus value too; the pipeline ignores it.
                        rdata_q <= bus.bus_rdata;
                        valid_q <= 1'b1;
                        state   <= S_DONE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        valid_q <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    if (!pipe_hold) begin
                        err_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Stall is combinational so the capture cycle itself already holds the pipeline.
    // NOTE: a continuous assign of a complete expression cannot infer a latch.
    assign stallreq_mem = (state == S_IDLE && mem_req_en) ||
                          (state == S_REQ) || (state == S_WAIT);

    // Bus fields come only from registers, so they are stable throughout REQ.
    assign bus.bus_req   = req_q;
    assign bus.bus_wr    = wr_q;
    assign bus.bus_size  = size_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;

    assign rdata_out   = rdata_q;
    assign rdata_valid = valid_q;
    assign bus_err     = err_q;

endmodule
